// File: rtl/debug_clk_div_ctrl.sv
// debug_clk_div_ctrl
// Run-time controller for the debug clock divider. It starts, stops and
// retunes a divided clock (div_clk) derived from clk_ref. A new half-period
// is held in a one-entry buffer and only takes effect on a period boundary,
// so div_clk never produces a runt pulse.
//
// Optional feature: define DEBUG_CLK_DIV_EDGE_CNT_EN to add the 16-bit
// edge_cnt output, which counts rising edges of div_clk since the last start.
module debug_clk_div_ctrl #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 4
) (
    input  logic             clk_ref,
    input  logic             rst,
    input  logic             run_en,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             running
`ifdef DEBUG_CLK_DIV_EDGE_CNT_EN
    ,
    output logic [15:0]      edge_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] pend_half;
    logic             pend_valid;

    logic active;     // counting (RUNNING or STOPPING)
    logic wrap;       // counter at the last cycle of the current phase
    logic fall_now;   // this edge ends a high phase
    logic stop_low;   // stop requested during a low phase: truncate it
    logic toggle;     // this edge flips div_clk
    logic xfer;       // configuration handshake on this edge
    logic apply;      // pending half-period is loaded on this edge

    // Decode the events the state machine and datapath act on this cycle.
    always_comb begin
        active   = (state != ST_STOPPED);
        wrap     = (cnt == half - ONE);
        fall_now = active && wrap && div_clk;
        stop_low = (state == ST_RUNNING) && !run_en && !div_clk;
        toggle   = active && wrap && !stop_low;
        xfer     = cfg_valid && !pend_valid;
        // A stopped divider retunes at once; a running one only at a fall, so
        // the new value governs the following low phase in full.
        apply    = pend_valid && ((state == ST_STOPPED) || fall_now);
    end

    // State register.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state <= ST_STOPPED;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            state <= state_nxt;
        end
    end

    // Next-state logic: a stop waits for the high phase to finish so the last
    // high pulse is never shortened.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt; no latch.
        state_nxt = state;
        unique case (state)
            ST_STOPPED: begin
                if (run_en) state_nxt = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (!run_en) begin
                    if (!div_clk || fall_now) state_nxt = ST_STOPPED;
                    else                      state_nxt = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (run_en)        state_nxt = ST_RUNNING;
                else if (fall_now) state_nxt = ST_STOPPED;
            end
            default: state_nxt = ST_STOPPED;
        endcase
    end

    // Output decode from the registered state and buffer flag.
    always_comb begin
        running   = (state != ST_STOPPED);
        cfg_ready = !pend_valid;
    end

    // Phase counter, divided clock and its edge strobes.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            div_clk  <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            if (!active || stop_low || wrap) cnt <= '0;
            else                             cnt <= cnt + ONE;

            if (!active)     div_clk <= 1'b0;
            else if (toggle) div_clk <= ~div_clk;

            rise_stb <= toggle && !div_clk;
            fall_stb <= toggle && div_clk;
        end
    end

    // Half-period register and the one-entry pending buffer. Apply and a new
    // handshake are exclusive: a handshake needs the buffer empty.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            half       <= HALF_RST;
            pend_half  <= '0;
            pend_valid <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= xfer && (cfg_half == '0);
            if (apply) begin
                half       <= pend_half;
                pend_valid <= 1'b0;
            end else if (xfer && (cfg_half != '0)) begin
                pend_half  <= cfg_half;
                pend_valid <= 1'b1;
            end
        end
    end

`ifdef DEBUG_CLK_DIV_EDGE_CNT_EN
    // Rising-edge counter: cleared on each start, wraps naturally at 16 bits.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            edge_cnt <= 16'd0;
        end else if ((state == ST_STOPPED) && run_en) begin
            edge_cnt <= 16'd0;
        end else if (toggle && !div_clk) begin
            edge_cnt <= edge_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_debug_clk_div_ctrl.sv
// tb_debug_clk_div_ctrl
// Directed bench for debug_clk_div_ctrl (CNT_W=8, DEFAULT_HALF=4). The
// stimulus process queues every expected strobe with the clk_ref cycle it
// must appear in; a monitor pops and compares whenever a strobe is seen.
// Edge counter checks are compiled when DEBUG_CLK_DIV_EDGE_CNT_EN is defined.
module tb_debug_clk_div_ctrl;

    typedef enum int {EV_RISE = 0, EV_FALL = 1, EV_ERR = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    logic       clk_ref;
    logic       rst;
    logic       run_en;
    logic [7:0] cfg_half;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_err;
    logic       div_clk;
    logic       rise_stb;
    logic       fall_stb;
    logic       running;
`ifdef DEBUG_CLK_DIV_EDGE_CNT_EN
    logic [15:0] edge_cnt;
`endif

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    ev_t exp_q[$];

    debug_clk_div_ctrl #(.CNT_W(8), .DEFAULT_HALF(4)) dut (
        .clk_ref  (clk_ref),
        .rst      (rst),
        .run_en   (run_en),
        .cfg_half (cfg_half),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .div_clk  (div_clk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .running  (running)
`ifdef DEBUG_CLK_DIV_EDGE_CNT_EN
        ,
        .edge_cnt (edge_cnt)
`endif
    );

    initial begin
        clk_ref = 1'b0;
        forever #5 clk_ref = ~clk_ref;
    end

    // Number of rising clk_ref edges so far; stable at every falling edge.
    always @(posedge clk_ref) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input ev_kind_t kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", int'(kind), -1);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(kind), int'(e.kind));
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: every strobe the DUT presents must match the queue head.
    always @(negedge clk_ref) begin
        if (rise_stb) pop_check(EV_RISE);
        if (fall_stb) pop_check(EV_FALL);
        if (cfg_err)  pop_check(EV_ERR);
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk_ref);
    endtask

    initial begin
        int t;
        int s;
        int u;
        int v;
        int w;
        int x;
        localparam int N1 = 20;

        rst       = 1'b1;
        run_en    = 1'b0;
        cfg_half  = 8'd0;
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk_ref);

        // Reset state.
        check("rst_div_clk",   int'(div_clk),   0);
        check("rst_rise_stb",  int'(rise_stb),  0);
        check("rst_fall_stb",  int'(fall_stb),  0);
        check("rst_cfg_err",   int'(cfg_err),   0);
        check("rst_running",   int'(running),   0);
        check("rst_cfg_ready", int'(cfg_ready), 1);

        // Basic run with H=4, retune to 2, zero config, retune back to 4,
        // then stop during a high phase.
        rst    = 1'b0;
        t      = cyc;
        run_en = 1'b1;
        expect_ev(EV_RISE, t + 5);
        expect_ev(EV_FALL, t + 9);
        expect_ev(EV_RISE, t + 13);
        expect_ev(EV_FALL, t + 17);
        expect_ev(EV_RISE, t + 19);
        expect_ev(EV_ERR,  t + 20);
        expect_ev(EV_FALL, t + 21);
        expect_ev(EV_RISE, t + 23);
        expect_ev(EV_FALL, t + 25);
        expect_ev(EV_RISE, t + 29);
        expect_ev(EV_FALL, t + 33);

        wait_until(t + 2);
        check("run_running", int'(running), 1);
        wait_until(t + 6);
        check("run_div_high", int'(div_clk), 1);

        wait_until(t + 14);
        cfg_half  = 8'd2;
        cfg_valid = 1'b1;
        wait_until(t + 15);
        cfg_valid = 1'b0;
        check("retune_ready_busy0", int'(cfg_ready), 0);
        wait_until(t + 16);
        check("retune_ready_busy1", int'(cfg_ready), 0);
        wait_until(t + 17);
        check("retune_ready_back", int'(cfg_ready), 1);

        wait_until(t + 19);
        cfg_half  = 8'd0;
        cfg_valid = 1'b1;
        wait_until(t + 20);
        cfg_valid = 1'b0;
        check("zero_ready_stays", int'(cfg_ready), 1);
        wait_until(t + 21);
        check("zero_ready_after", int'(cfg_ready), 1);
        cfg_half  = 8'd4;
        cfg_valid = 1'b1;
        wait_until(t + 22);
        cfg_valid = 1'b0;

        wait_until(t + 30);
        run_en = 1'b0;
        wait_until(t + 32);
        check("stopping_running", int'(running), 1);
        check("stopping_div_high", int'(div_clk), 1);
        wait_until(t + 33);
        check("stopped_running", int'(running), 0);
        check("stopped_div_low", int'(div_clk), 0);

        // Restart; reassert run_en inside STOPPING; then stop in a low phase.
        wait_until(t + 36);
        s      = cyc;
        run_en = 1'b1;
        expect_ev(EV_RISE, s + 5);
        expect_ev(EV_FALL, s + 9);
        expect_ev(EV_RISE, s + 13);
        expect_ev(EV_FALL, s + 17);
        wait_until(s + 14);
        run_en = 1'b0;
        wait_until(s + 15);
        run_en = 1'b1;
        check("cancel_stop_running0", int'(running), 1);
        wait_until(s + 16);
        check("cancel_stop_running1", int'(running), 1);
        wait_until(s + 18);
        check("cancel_stop_running2", int'(running), 1);
        run_en = 1'b0;
        wait_until(s + 19);
        check("low_stop_running", int'(running), 0);
        check("low_stop_div", int'(div_clk), 0);

        // Config while stopped takes effect on the next edge (H=3).
        wait_until(s + 21);
        cfg_half  = 8'd3;
        cfg_valid = 1'b1;
        wait_until(s + 22);
        cfg_valid = 1'b0;
        check("stopped_cfg_busy", int'(cfg_ready), 0);
        wait_until(s + 23);
        check("stopped_cfg_applied", int'(cfg_ready), 1);

        wait_until(s + 24);
        u      = cyc;
        run_en = 1'b1;
        expect_ev(EV_RISE, u + 4);
        expect_ev(EV_FALL, u + 7);
        expect_ev(EV_RISE, u + 10);

        // Reset mid high phase with a pending value.
        wait_until(u + 10);
        cfg_half  = 8'd7;
        cfg_valid = 1'b1;
        wait_until(u + 11);
        cfg_valid = 1'b0;
        check("pend_before_rst", int'(cfg_ready), 0);
        check("div_before_rst", int'(div_clk), 1);
        rst    = 1'b1;
        run_en = 1'b0;
        #1;
        check("mid_rst_div", int'(div_clk), 0);
        check("mid_rst_running", int'(running), 0);
        check("mid_rst_ready", int'(cfg_ready), 1);
        repeat (2) @(negedge clk_ref);
        rst = 1'b0;

        // After reset H must be DEFAULT_HALF again (pending 7 lost).
        v      = cyc;
        run_en = 1'b1;
        expect_ev(EV_RISE, v + 5);
        expect_ev(EV_FALL, v + 9);
        wait_until(v + 10);
        run_en = 1'b0;
`ifdef DEBUG_CLK_DIV_EDGE_CNT_EN
        check("edge_cnt_one", int'(edge_cnt), 1);
`endif
        wait_until(v + 11);
        check("post_rst_stopped", int'(running), 0);

        // Minimum half-period H=1: div_clk = clk_ref/2.
        wait_until(v + 12);
        cfg_half  = 8'd1;
        cfg_valid = 1'b1;
        wait_until(v + 13);
        cfg_valid = 1'b0;
        wait_until(v + 15);
        w      = cyc;
        for (int k = 1; k <= N1; k++) begin
            expect_ev(EV_RISE, w + 2 * k);
            expect_ev(EV_FALL, w + 2 * k + 1);
        end
        run_en = 1'b1;
        wait_until(w + 2 * N1);
`ifdef DEBUG_CLK_DIV_EDGE_CNT_EN
        check("edge_cnt_n", int'(edge_cnt), N1);
`endif
        // Stop exactly on the fall edge: goes straight to STOPPED.
        run_en = 1'b0;
        wait_until(w + 2 * N1 + 1);
        check("h1_stop_running", int'(running), 0);
        check("h1_stop_div", int'(div_clk), 0);

        // Start then stop at once: the low phase is truncated, no strobes.
        wait_until(w + 2 * N1 + 3);
        x      = cyc;
        run_en = 1'b1;
        wait_until(x + 1);
        check("restart_running", int'(running), 1);
`ifdef DEBUG_CLK_DIV_EDGE_CNT_EN
        check("edge_cnt_cleared", int'(edge_cnt), 0);
`endif
        run_en = 1'b0;
        wait_until(x + 2);
        check("trunc_running", int'(running), 0);
        check("trunc_div", int'(div_clk), 0);

        wait_until(x + 8);
        check("events_outstanding", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
